pov_fb_write_arbiter: RTL and testbench
=======================================

# pov_fb_write_arbiter

Arbiter and sequencer in front of the POV display peripheral's memory-mapped register bus. It lets the CPU and a hardware column-fill requester (pattern/DMA engine) share the column-address / pixel-data / write-trigger register sequence without corrupting each other. A hardware request becomes an atomic 3-write burst followed by a 2-write restore of the CPU's shadowed COL_ADDR/PIXEL_DATA values. The block sits between the CPU bus decode and the peripheral's `cpu_*` ports.

## Interface
- `BASE_ADDR`, 32'hFFFF0000, peripheral register window base; window is BASE_ADDR..BASE_ADDR+0x1F (addr[31:5] match).
- `STARVE_LIMIT`, 8, consecutive IDLE cycles a pending HW request may lose to CPU window accesses before it is forced through; 0 = HW always wins.
- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cpu_addr`  in  32  CPU address.
- `cpu_data_in`  in  32  CPU write data.
- `cpu_wren`  in  1  CPU write enable.
- `cpu_rden`  in  1  CPU read enable.
- `cpu_stall`  out  1  CPU must hold its access this cycle; the access is not forwarded.
- `req_valid`  in  1  HW requester has a column update pending.
- `req_col`  in  8  target column 0-255.
- `req_rgb`  in  24  RGB value.
- `req_ready`  out  1  request accepted this cycle (valid && ready = handshake).
- `per_addr`  out  32  peripheral address.
- `per_wdata`  out  32  peripheral write data.
- `per_wren`  out  1  peripheral write enable.
- `per_rden`  out  1  peripheral read enable.
- `busy`  out  1  state != IDLE.
- `hw_done`  out  1  one-cycle pulse in the final restore cycle of a burst.

## Operation
- States: IDLE, HW_COL, HW_PIX, HW_WR, RST_COL, RST_PIX; fixed order HW_COL→HW_PIX→HW_WR→RST_COL→RST_PIX→IDLE, one cycle each, no early exit.
- Window access: (cpu_wren|cpu_rden) && cpu_addr[31:5]==BASE_ADDR[31:5]. Non-window CPU accesses are never stalled and never forwarded (per_wren/per_rden=0).
- IDLE, window access, no forced grant: forward combinationally (per_addr=cpu_addr, per_wdata=cpu_data_in, per_wren/per_rden copied), cpu_stall=0, req_ready=0.
- IDLE, req_valid, and (no window access or starve_cnt==STARVE_LIMIT): req_ready=1, latch req_col/req_rgb, go HW_COL; any window access that cycle gets cpu_stall=1.
- HW_COL: write BASE+0x0, data {24'b0,col}. HW_PIX: write BASE+0x4, data {8'b0,rgb}. HW_WR: write BASE+0x8, data 0. RST_COL: write BASE+0x0, {24'b0,shadow_col}. RST_PIX: write BASE+0x4, {8'b0,shadow_pix}; hw_done=1.
- In every non-IDLE state per_rden=0 and any window access gets cpu_stall=1.
- Shadows: forwarded CPU write to BASE+0x0 sets shadow_col<=data[7:0]; to BASE+0x4 sets shadow_pix<=data[23:0]. HW burst writes do not touch shadows.
- starve_cnt (saturating, width clog2(STARVE_LIMIT+1), min 1): increments in IDLE when req_valid && window access forwarded; cleared on grant or when req_valid=0.

## Timing
- Reset (reset=0), asynchronous: state=IDLE, shadow_col=0, shadow_pix=0, starve_cnt=0; while asserted all outputs 0 (cpu_stall, req_ready, per_*, busy, hw_done).
- Reset mid-burst: burst abandoned immediately, no further writes; after release, IDLE.
- Grant at cycle T: per writes at T+1 (col), T+2 (pix), T+3 (trigger), T+4, T+5 (restore); hw_done at T+5; IDLE at T+6, next grant possible at T+6.
- Back-to-back HW requests with no CPU traffic: one column every 6 cycles.
- CPU write to COL_ADDR/PIXEL_DATA in the cycle immediately after hw_done is forwarded normally and updates the shadow.
- All per_*/cpu_stall/req_ready outputs are combinational from state, latched request and CPU inputs; no added CPU latency in IDLE.

## Test plan
- CPU writes 0x12 to BASE+0x0, 0xABCDEF to BASE+0x4, then BASE+0x8 with req_valid=0 -> three same-cycle forwarded writes, cpu_stall=0, shadows 0x12/0xABCDEF.
- After the above, req_valid with col=0x40, rgb=0x00FF00 -> per writes (0x0,0x40),(0x4,0x00FF00),(0x8,0),(0x0,0x12),(0x4,0xABCDEF) on T+1..T+5, hw_done at T+5.
- CPU window write asserted during HW_PIX -> cpu_stall=1 through RST_PIX, write forwarded at T+6.
- CPU issues window accesses every cycle with req_valid held, STARVE_LIMIT=8 -> 8 CPU accesses forwarded, 9th cycle req_ready=1 and cpu_stall=1.
- CPU read of non-window address during a burst -> cpu_stall=0, per_rden=0.
- reset driven low at T+2 of a burst -> all outputs 0 asynchronously; after release, IDLE, shadows 0, no restore writes.

Source files
------------

// File: rtl/pov_fb_write_arbiter_if.sv
// Bundle of CPU-side, HW-requester-side and peripheral-side signals of the POV write arbiter.
// Latency: none, wires only.
// Backpressure: cpu_stall holds the CPU, req_ready acknowledges the HW requester.
interface pov_fb_write_arbiter_if;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_data_in;
   logic        cpu_wren;
   logic        cpu_rden;
   logic        cpu_stall;
   logic        req_valid;
   logic [7:0]  req_col;
   logic [23:0] req_rgb;
   logic        req_ready;
   logic [31:0] per_addr;
   logic [31:0] per_wdata;
   logic        per_wren;
   logic        per_rden;
   logic        busy;
   logic        hw_done;

   modport master (
      output cpu_addr, cpu_data_in, cpu_wren, cpu_rden,
      output req_valid, req_col, req_rgb,
      input  cpu_stall, req_ready,
      input  per_addr, per_wdata, per_wren, per_rden, busy, hw_done
   );

   modport slave (
      input  cpu_addr, cpu_data_in, cpu_wren, cpu_rden,
      input  req_valid, req_col, req_rgb,
      output cpu_stall, req_ready,
      output per_addr, per_wdata, per_wren, per_rden, busy, hw_done
   );
endinterface

// File: rtl/pov_fb_write_arbiter.sv
// Shares the POV peripheral register bus between the CPU and a HW column-fill requester.
// Latency: CPU window accesses forwarded in the same cycle; HW request = 5-cycle write burst.
// Backpressure: cpu_stall while a burst owns the bus; req_ready pulses on grant.
module pov_fb_write_arbiter #(
   parameter logic [31:0] BASE_ADDR    = 32'hFFFF0000,
   parameter int          STARVE_LIMIT = 8
) (
   input logic clk,
   input logic reset,
   pov_fb_write_arbiter_if.slave bus
);
   localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

   typedef enum logic [2:0] {IDLE, HW_COL, HW_PIX, HW_WR, RST_COL, RST_PIX} state_t;

   state_t        state, state_nxt;
   logic [7:0]    col_q;
   logic [23:0]   rgb_q;
   logic [7:0]    shadow_col;
   logic [23:0]   shadow_pix;
   logic [CW-1:0] starve_cnt;

   logic        win, at_limit, grant, fwd;
   logic        stall, ready, wren, rden, busy_c, done;
   logic [31:0] addr, wdata;

   assign win      = (bus.cpu_wren | bus.cpu_rden) && (bus.cpu_addr[31:5] == BASE_ADDR[31:5]);
   assign at_limit = (starve_cnt == CW'(STARVE_LIMIT));

   // Every output is gated by reset so nothing leaks to the peripheral while it is held.
   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      fwd       = 1'b0;
      stall     = 1'b0;
      ready     = 1'b0;
      wren      = 1'b0;
      rden      = 1'b0;
      done      = 1'b0;
      addr      = 32'd0;
      wdata     = 32'd0;
      busy_c    = 1'b0;
      if (reset) begin
         busy_c = (state != IDLE);
         stall  = (state != IDLE) && win;
         case (state)
            IDLE: begin
               if (bus.req_valid && (!win || at_limit)) begin
                  grant     = 1'b1;
                  ready     = 1'b1;
                  stall     = win;
                  state_nxt = HW_COL;
               end else if (win) begin
                  fwd   = 1'b1;
                  addr  = bus.cpu_addr;
                  wdata = bus.cpu_data_in;
                  wren  = bus.cpu_wren;
                  rden  = bus.cpu_rden;
               end
            end
            HW_COL: begin
               wren      = 1'b1;
               addr      = BASE_ADDR;
               wdata     = {24'd0, col_q};
               state_nxt = HW_PIX;
            end
            HW_PIX: begin
               wren      = 1'b1;
               addr      = BASE_ADDR + 32'h4;
               wdata     = {8'd0, rgb_q};
               state_nxt = HW_WR;
            end
            HW_WR: begin
               wren      = 1'b1;
               addr      = BASE_ADDR + 32'h8;
               state_nxt = RST_COL;
            end
            RST_COL: begin
               wren      = 1'b1;
               addr      = BASE_ADDR;
               wdata     = {24'd0, shadow_col};
               state_nxt = RST_PIX;
            end
            RST_PIX: begin
               wren      = 1'b1;
               addr      = BASE_ADDR + 32'h4;
               wdata     = {8'd0, shadow_pix};
               done      = 1'b1;
               state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         col_q      <= 8'd0;
         rgb_q      <= 24'd0;
         shadow_col <= 8'd0;
         shadow_pix <= 24'd0;
         starve_cnt <= '0;
      end else begin
         if (grant) begin
            col_q <= bus.req_col;
            rgb_q <= bus.req_rgb;
         end
         // Shadows track only what the CPU itself wrote, so the burst can put it back.
         if (fwd && bus.cpu_wren && bus.cpu_addr == BASE_ADDR)
            shadow_col <= bus.cpu_data_in[7:0];
         if (fwd && bus.cpu_wren && bus.cpu_addr == BASE_ADDR + 32'h4)
            shadow_pix <= bus.cpu_data_in[23:0];
         if (grant || !bus.req_valid)
            starve_cnt <= '0;
         else if (fwd && !at_limit)
            starve_cnt <= starve_cnt + 1'b1;
      end
   end

   assign bus.cpu_stall = stall;
   assign bus.req_ready = ready;
   assign bus.per_addr  = addr;
   assign bus.per_wdata = wdata;
   assign bus.per_wren  = wren;
   assign bus.per_rden  = rden;
   assign bus.busy      = busy_c;
   assign bus.hw_done   = done;
endmodule

// File: tb/tb_pov_fb_write_arbiter.sv
// Bench for pov_fb_write_arbiter: directed stimulus, expected peripheral accesses queued
// into a scoreboard and popped by an independent negedge monitor.
module tb_pov_fb_write_arbiter;
   localparam logic [31:0] BASE = 32'hFFFF0000;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   pov_fb_write_arbiter_if bus ();

   pov_fb_write_arbiter #(.BASE_ADDR(BASE), .STARVE_LIMIT(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic        wr;
      logic        rd;
      logic        done;
   } acc_t;

   acc_t sb[$];
   int   tests = 0;
   int   fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic acc_t wr(input logic [31:0] a, input logic [31:0] d, input logic dn);
      acc_t x;
      x.addr = a; x.data = d; x.wr = 1'b1; x.rd = 1'b0; x.done = dn;
      return x;
   endfunction

   task automatic push_burst(input logic [7:0] col, input logic [23:0] rgb,
                             input logic [7:0] scol, input logic [23:0] spix);
      sb.push_back(wr(BASE,         {24'd0, col},  1'b0));
      sb.push_back(wr(BASE + 32'h4, {8'd0, rgb},   1'b0));
      sb.push_back(wr(BASE + 32'h8, 32'd0,         1'b0));
      sb.push_back(wr(BASE,         {24'd0, scol}, 1'b0));
      sb.push_back(wr(BASE + 32'h4, {8'd0, spix},  1'b1));
   endtask

   // Monitor: every peripheral access must match the head of the scoreboard.
   always @(negedge clk) begin
      if (bus.per_wren || bus.per_rden) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_access: got addr %h data %h wren %0b rden %0b, expected none (t=%0t)",
                     bus.per_addr, bus.per_wdata, bus.per_wren, bus.per_rden, $time);
         end else begin
            acc_t e;
            e = sb.pop_front();
            chk("per_addr",  bus.per_addr,  e.addr);
            chk("per_wdata", bus.per_wdata, e.data);
            chk("per_wren",  32'(bus.per_wren), 32'(e.wr));
            chk("per_rden",  32'(bus.per_rden), 32'(e.rd));
            chk("hw_done",   32'(bus.hw_done),  32'(e.done));
         end
      end
   end

   task automatic idle_in();
      bus.cpu_addr = 32'd0; bus.cpu_data_in = 32'd0;
      bus.cpu_wren = 1'b0;  bus.cpu_rden = 1'b0;
      bus.req_valid = 1'b0; bus.req_col = 8'd0; bus.req_rgb = 24'd0;
   endtask

   task automatic cpu_wr(input logic [31:0] a, input logic [31:0] d);
      bus.cpu_addr = a; bus.cpu_data_in = d; bus.cpu_wren = 1'b1; bus.cpu_rden = 1'b0;
   endtask

   task automatic hw_req(input logic [7:0] col, input logic [23:0] rgb);
      bus.req_valid = 1'b1; bus.req_col = col; bus.req_rgb = rgb;
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_stall"}, 32'(bus.cpu_stall), 32'd0);
      chk({tag, "_ready"}, 32'(bus.req_ready), 32'd0);
      chk({tag, "_wren"},  32'(bus.per_wren),  32'd0);
      chk({tag, "_rden"},  32'(bus.per_rden),  32'd0);
      chk({tag, "_addr"},  bus.per_addr,       32'd0);
      chk({tag, "_wdata"}, bus.per_wdata,      32'd0);
      chk({tag, "_busy"},  32'(bus.busy),      32'd0);
      chk({tag, "_done"},  32'(bus.hw_done),   32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset held with a window write and a HW request present: outputs must stay 0.
      idle_in();
      reset = 1'b0;
      cpu_wr(BASE, 32'h1);
      hw_req(8'h01, 24'h1);
      #12;
      chk_zero("rst");
      nxt();
      idle_in();
      reset = 1'b1;

      // Forwarded CPU writes load the shadows; non-window traffic is ignored.
      cpu_wr(BASE, 32'h12);
      sb.push_back(wr(BASE, 32'h12, 1'b0));
      @(negedge clk); chk("fwd0_stall", 32'(bus.cpu_stall), 32'd0);
      nxt();
      cpu_wr(BASE + 32'h4, 32'hABCDEF);
      sb.push_back(wr(BASE + 32'h4, 32'hABCDEF, 1'b0));
      @(negedge clk); chk("fwd4_stall", 32'(bus.cpu_stall), 32'd0);
      nxt();
      cpu_wr(BASE + 32'h8, 32'h1);
      sb.push_back(wr(BASE + 32'h8, 32'h1, 1'b0));
      @(negedge clk); chk("fwd8_stall", 32'(bus.cpu_stall), 32'd0);
      nxt();
      cpu_wr(32'h0000_1000, 32'hDEAD);
      @(negedge clk); chk("nonwin_stall", 32'(bus.cpu_stall), 32'd0);
      nxt();

      // HW burst: non-window read at T+1, window write blocked from T+2 until T+6.
      idle_in();
      hw_req(8'h40, 24'h00FF00);
      push_burst(8'h40, 24'h00FF00, 8'h12, 24'hABCDEF);
      @(negedge clk);
      chk("grant_ready", 32'(bus.req_ready), 32'd1);
      chk("grant_busy",  32'(bus.busy),      32'd0);
      nxt();
      idle_in();
      bus.cpu_rden = 1'b1; bus.cpu_addr = 32'h0000_2000;
      @(negedge clk);
      chk("burst_nonwin_stall", 32'(bus.cpu_stall), 32'd0);
      chk("burst_busy",         32'(bus.busy),      32'd1);
      nxt();
      cpu_wr(BASE, 32'h77);
      for (int k = 2; k <= 5; k++) begin
         @(negedge clk);
         chk("burst_win_stall", 32'(bus.cpu_stall), 32'd1);
         nxt();
      end
      sb.push_back(wr(BASE, 32'h77, 1'b0));
      @(negedge clk);
      chk("after_burst_stall", 32'(bus.cpu_stall), 32'd0);
      chk("after_burst_busy",  32'(bus.busy),      32'd0);
      nxt();

      // Starvation: eight window accesses win, the ninth cycle forces the grant.
      idle_in();
      hw_req(8'h05, 24'h123456);
      for (int i = 0; i < 8; i++) begin
         cpu_wr(BASE + 32'h10, 32'(i));
         sb.push_back(wr(BASE + 32'h10, 32'(i), 1'b0));
         @(negedge clk);
         chk("starve_ready", 32'(bus.req_ready), 32'd0);
         chk("starve_stall", 32'(bus.cpu_stall), 32'd0);
         nxt();
      end
      cpu_wr(BASE + 32'h10, 32'h8);
      push_burst(8'h05, 24'h123456, 8'h77, 24'hABCDEF);
      @(negedge clk);
      chk("forced_ready", 32'(bus.req_ready), 32'd1);
      chk("forced_stall", 32'(bus.cpu_stall), 32'd1);
      nxt();
      idle_in();
      repeat (5) nxt();

      // Back-to-back requests: one grant every 6 cycles, request fields latched at grant.
      for (int k = 0; k < 12; k++) begin
         hw_req((k == 0) ? 8'h01 : 8'h02, (k == 0) ? 24'h000001 : 24'h000002);
         if (k == 0) push_burst(8'h01, 24'h000001, 8'h77, 24'hABCDEF);
         if (k == 6) push_burst(8'h02, 24'h000002, 8'h77, 24'hABCDEF);
         @(negedge clk);
         chk("b2b_ready", 32'(bus.req_ready), (k % 6 == 0) ? 32'd1 : 32'd0);
         nxt();
      end
      idle_in();
      nxt();

      // Reset in the middle of a burst: only the column write escapes.
      hw_req(8'h09, 24'h0A0B0C);
      sb.push_back(wr(BASE, 32'h09, 1'b0));
      @(negedge clk); chk("midrst_ready", 32'(bus.req_ready), 32'd1);
      nxt();
      idle_in();
      nxt();
      reset = 1'b0;
      cpu_wr(BASE, 32'h55);
      #1;
      chk_zero("midrst");
      nxt();
      idle_in();
      reset = 1'b1;
      @(negedge clk); chk("postrst_busy", 32'(bus.busy), 32'd0);
      nxt();
      hw_req(8'h0C, 24'h0D0E0F);
      push_burst(8'h0C, 24'h0D0E0F, 8'h00, 24'h000000);
      @(negedge clk); chk("postrst_ready", 32'(bus.req_ready), 32'd1);
      nxt();
      idle_in();
      repeat (7) nxt();

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
